// File: rtl/case5_result_collector.sv
// Collects case5 {x,y,z} samples into frames and reports per-output ones-counts.
// Optional MISR signature on out_sig when CASE5_MISR_EN is defined (else out_sig = 8'h00).
module case5_result_collector #(
    parameter int CNT_W     = 8,
    parameter int FRAME_LEN = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_x,
    input  logic             in_y,
    input  logic             in_z,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_cnt_x,
    output logic [CNT_W-1:0] out_cnt_y,
    output logic [CNT_W-1:0] out_cnt_z,
    output logic [7:0]       out_sig,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        REPORT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] FRAME_LEN_C = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] ZERO_C      = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE_C       = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r;
    logic [CNT_W-1:0] acc_x_r;
    logic [CNT_W-1:0] acc_y_r;
    logic [CNT_W-1:0] acc_z_r;
    logic [CNT_W-1:0] idx_r;
    logic [CNT_W-1:0] out_cnt_x_r;
    logic [CNT_W-1:0] out_cnt_y_r;
    logic [CNT_W-1:0] out_cnt_z_r;
    logic             out_valid_r;

    logic             accept_s;
    logic             last_s;
    logic [CNT_W-1:0] acc_x_nxt_s;
    logic [CNT_W-1:0] acc_y_nxt_s;
    logic [CNT_W-1:0] acc_z_nxt_s;
    logic [CNT_W-1:0] idx_nxt_s;

    assign in_ready    = !flush && (state_r != REPORT);
    assign accept_s    = in_valid && in_ready;
    assign acc_x_nxt_s = acc_x_r + {{(CNT_W-1){1'b0}}, in_x};
    assign acc_y_nxt_s = acc_y_r + {{(CNT_W-1){1'b0}}, in_y};
    assign acc_z_nxt_s = acc_z_r + {{(CNT_W-1){1'b0}}, in_z};
    assign idx_nxt_s   = idx_r + ONE_C;
    assign last_s      = (idx_nxt_s == FRAME_LEN_C);

    assign out_valid = out_valid_r;
    assign out_cnt_x = out_cnt_x_r;
    assign out_cnt_y = out_cnt_y_r;
    assign out_cnt_z = out_cnt_z_r;
    assign busy      = (state_r != IDLE);

`ifdef CASE5_MISR_EN
    logic [7:0] misr_r;
    logic [7:0] out_sig_r;
    logic [7:0] misr_nxt_s;

    // One MISR step: shift left, fold polynomial 0x1D on carry-out, inject {x,y,z}.
    function automatic logic [7:0] misr_step(input logic [7:0] cur, input logic [2:0] din);
        misr_step = {cur[6:0], 1'b0} ^ (cur[7] ? 8'h1D : 8'h00) ^ {5'b00000, din};
    endfunction

    assign misr_nxt_s = misr_step(misr_r, {in_x, in_y, in_z});
    assign out_sig    = out_sig_r;

    // Signature register: advances on accept, reseeds at frame end, flush and reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            misr_r    <= 8'hFF;
            out_sig_r <= 8'h00;
        end else if ((state_r != REPORT) && flush) begin
            misr_r    <= 8'hFF;
        end else if (accept_s && last_s) begin
            out_sig_r <= misr_nxt_s;
            misr_r    <= 8'hFF;
        end else if (accept_s) begin
            misr_r    <= misr_nxt_s;
        end else begin
            misr_r    <= misr_r;
        end
    end
`else
    assign out_sig = 8'h00;
`endif

    // Frame FSM: accumulation, summary latch and result handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            acc_x_r     <= ZERO_C;
            acc_y_r     <= ZERO_C;
            acc_z_r     <= ZERO_C;
            idx_r       <= ZERO_C;
            out_cnt_x_r <= ZERO_C;
            out_cnt_y_r <= ZERO_C;
            out_cnt_z_r <= ZERO_C;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE, ACCUM: begin
                    if (flush) begin
                        acc_x_r <= ZERO_C;
                        acc_y_r <= ZERO_C;
                        acc_z_r <= ZERO_C;
                        idx_r   <= ZERO_C;
                        state_r <= IDLE;
                    end else if (accept_s && last_s) begin
                        out_cnt_x_r <= acc_x_nxt_s;
                        out_cnt_y_r <= acc_y_nxt_s;
                        out_cnt_z_r <= acc_z_nxt_s;
                        out_valid_r <= 1'b1;
                        acc_x_r     <= ZERO_C;
                        acc_y_r     <= ZERO_C;
                        acc_z_r     <= ZERO_C;
                        idx_r       <= ZERO_C;
                        state_r     <= REPORT;
                    end else if (accept_s) begin
                        acc_x_r <= acc_x_nxt_s;
                        acc_y_r <= acc_y_nxt_s;
                        acc_z_r <= acc_z_nxt_s;
                        idx_r   <= idx_nxt_s;
                        state_r <= ACCUM;
                    end else begin
                        state_r <= state_r;
                    end
                end
                REPORT: begin
                    // Summary stays put until the consumer takes it; flush has no effect here.
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end else begin
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    acc_x_r     <= ZERO_C;
                    acc_y_r     <= ZERO_C;
                    acc_z_r     <= ZERO_C;
                    idx_r       <= ZERO_C;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_case5_result_collector.sv
// Scoreboard bench: a FRAME_LEN=4 collector for handshake/flush/reset cases and a
// FRAME_LEN=255 collector for the full-count case.
module tb_case5_result_collector;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       in_valid_a, in_valid_b;
    logic       in_ready_a, in_ready_b;
    logic       in_x, in_y, in_z;
    logic       out_valid_a, out_valid_b;
    logic       out_ready_a, out_ready_b;
    logic [7:0] cnt_x_a, cnt_y_a, cnt_z_a, sig_a;
    logic [7:0] cnt_x_b, cnt_y_b, cnt_z_b, sig_b;
    logic       busy_a, busy_b;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [7:0] cx;
        logic [7:0] cy;
        logic [7:0] cz;
        logic [7:0] sig;
    } frame_t;

    frame_t sb_q[$];

    int         m_acc_x, m_acc_y, m_acc_z, m_idx;
    logic [7:0] m_misr;
    int         b_accepts;

    always #5 clk = ~clk;

    case5_result_collector #(.CNT_W(8), .FRAME_LEN(4)) dut_a (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid_a), .in_ready(in_ready_a),
        .in_x(in_x), .in_y(in_y), .in_z(in_z),
        .out_valid(out_valid_a), .out_ready(out_ready_a),
        .out_cnt_x(cnt_x_a), .out_cnt_y(cnt_y_a), .out_cnt_z(cnt_z_a),
        .out_sig(sig_a), .busy(busy_a)
    );

    case5_result_collector #(.CNT_W(8), .FRAME_LEN(255)) dut_b (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_x(in_x), .in_y(in_y), .in_z(in_z),
        .out_valid(out_valid_b), .out_ready(out_ready_b),
        .out_cnt_x(cnt_x_b), .out_cnt_y(cnt_y_b), .out_cnt_z(cnt_z_b),
        .out_sig(sig_b), .busy(busy_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] misr_model(input logic [7:0] cur, input logic [2:0] d);
        logic [7:0] nxt;
        nxt = {cur[6:0], 1'b0};
        if (cur[7]) nxt = nxt ^ 8'h1D;
        return nxt ^ {5'b00000, d};
    endfunction

    function automatic logic [7:0] sig_expect(input logic [7:0] misr);
`ifdef CASE5_MISR_EN
        return misr;
`else
        return (misr & 8'h00);
`endif
    endfunction

    task automatic model_clear();
        m_acc_x = 0; m_acc_y = 0; m_acc_z = 0; m_idx = 0;
        m_misr  = 8'hFF;
    endtask

    // Present one sample and wait (bounded) until the selected DUT takes it.
    task automatic send(input logic [2:0] s, input bit to_b);
        bit done;
        frame_t f;
        done = 1'b0;
        {in_x, in_y, in_z} = s;
        if (to_b) in_valid_b = 1'b1; else in_valid_a = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if ((to_b ? in_ready_b : in_ready_a) == 1'b1) done = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        check_eq(to_b ? "accept_b" : "accept_a", {31'd0, done}, 32'd1);
        if (done && to_b) b_accepts++;
        if (done && !to_b) begin
            m_acc_x += int'(s[2]);
            m_acc_y += int'(s[1]);
            m_acc_z += int'(s[0]);
            m_idx++;
            m_misr = misr_model(m_misr, s);
            if (m_idx == 4) begin
                f.cx = 8'(m_acc_x); f.cy = 8'(m_acc_y); f.cz = 8'(m_acc_z);
                f.sig = sig_expect(m_misr);
                sb_q.push_back(f);
                model_clear();
            end
        end
    endtask

    // Scoreboard consumer: compare each summary the DUT hands over.
    always @(negedge clk) begin
        frame_t e;
        if (!rst && out_valid_a && out_ready_a) begin
            check_eq("sb_pending", {31'd0, sb_q.size() != 0}, 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check_eq("frame_cnt_x", {24'd0, cnt_x_a}, {24'd0, e.cx});
                check_eq("frame_cnt_y", {24'd0, cnt_y_a}, {24'd0, e.cy});
                check_eq("frame_cnt_z", {24'd0, cnt_z_a}, {24'd0, e.cz});
                check_eq("frame_sig",   {24'd0, sig_a},   {24'd0, e.sig});
            end
        end
    end

    task automatic drain(input string tag);
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk);
        #1;
        check_eq(tag, sb_q.size(), 32'd0);
    endtask

    initial begin
        frame_t held;
        bit     got;
        rst = 1'b1; flush = 1'b0;
        in_valid_a = 1'b0; in_valid_b = 1'b0;
        in_x = 1'b0; in_y = 1'b0; in_z = 1'b0;
        out_ready_a = 1'b1; out_ready_b = 1'b1;
        b_accepts = 0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_out_valid", {31'd0, out_valid_a}, 32'd0);
        check_eq("rst_cnt",       {8'd0, cnt_x_a, cnt_y_a, cnt_z_a}, 32'd0);
        check_eq("rst_sig",       {24'd0, sig_a}, 32'd0);
        check_eq("rst_busy",      {31'd0, busy_a}, 32'd0);
        rst = 1'b0;
        #1;
        check_eq("rst_in_ready",  {31'd0, in_ready_a}, 32'd1);

        // 1: one frame back to back, consumer always ready
        send(3'b111, 1'b0); send(3'b100, 1'b0); send(3'b101, 1'b0);
        check_eq("t1_busy_mid", {31'd0, busy_a}, 32'd1);
        send(3'b000, 1'b0);
        check_eq("t1_valid_lat1", {31'd0, out_valid_a}, 32'd1);
        drain("t1_drain");
        check_eq("t1_busy_after", {31'd0, busy_a}, 32'd0);

        // 2: back-pressure with in_valid held through REPORT
        out_ready_a = 1'b0;
        send(3'b011, 1'b0); send(3'b110, 1'b0); send(3'b010, 1'b0); send(3'b111, 1'b0);
        held = sb_q[0];
        {in_x, in_y, in_z} = 3'b110;
        in_valid_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("t2_hold_valid", {31'd0, out_valid_a}, 32'd1);
            check_eq("t2_in_ready",   {31'd0, in_ready_a}, 32'd0);
            check_eq("t2_hold_cnt", {8'd0, cnt_x_a, cnt_y_a, cnt_z_a},
                     {8'd0, held.cx, held.cy, held.cz});
            @(posedge clk);
            #1;
        end
        out_ready_a = 1'b1;
        @(posedge clk);
        #1;
        check_eq("t2_idle", {31'd0, busy_a}, 32'd0);
        send(3'b110, 1'b0); send(3'b001, 1'b0); send(3'b101, 1'b0); send(3'b100, 1'b0);
        drain("t2_drain");

        // 3: flush with a simultaneous sample
        send(3'b111, 1'b0); send(3'b111, 1'b0);
        flush = 1'b1; {in_x, in_y, in_z} = 3'b111; in_valid_a = 1'b1;
        @(negedge clk);
        check_eq("t3_flush_ready", {31'd0, in_ready_a}, 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid_a = 1'b0;
        check_eq("t3_flush_idle", {31'd0, busy_a}, 32'd0);
        model_clear();
        for (int i = 0; i < 4; i++) send(3'b001, 1'b0);
        drain("t3_drain");

        // 4: reset while a summary is being held
        out_ready_a = 1'b0;
        send(3'b101, 1'b0); send(3'b011, 1'b0); send(3'b111, 1'b0); send(3'b001, 1'b0);
        @(posedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb_q.delete();
        model_clear();
        check_eq("t4_valid", {31'd0, out_valid_a}, 32'd0);
        check_eq("t4_cnt",   {8'd0, cnt_x_a, cnt_y_a, cnt_z_a}, 32'd0);
        check_eq("t4_sig",   {24'd0, sig_a}, 32'd0);
        out_ready_a = 1'b1;
        send(3'b111, 1'b0); send(3'b100, 1'b0); send(3'b101, 1'b0); send(3'b000, 1'b0);
        drain("t4_drain");

        // 5: 255-sample frame of all ones on the long instance
        for (int i = 0; i < 255; i++) send(3'b111, 1'b1);
        check_eq("t5_accepts", b_accepts, 32'd255);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (out_valid_b) got = 1'b1;
            else @(posedge clk);
        end
        check_eq("t5_valid", {31'd0, got}, 32'd1);
        check_eq("t5_cnt", {8'd0, cnt_x_b, cnt_y_b, cnt_z_b}, {8'd0, 8'd255, 8'd255, 8'd255});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
